// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates RV32I branch conditions, computes the
// corrected next PC, and trains a 2-bit-counter branch history table.
module branch_unit #(
    parameter int Size      = 32,
    parameter int BHT_Depth = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Size-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic [Size-1:0]  resolve_pc,
    input  logic [Size-1:0]  rs1_data,
    input  logic [Size-1:0]  rs2_data,
    input  logic [2:0]       func3,
    input  logic [Size-1:0]  imm,
    input  logic             pred_taken_in,
    input  logic             flush,
    output logic             out_valid,
    output logic             branch_taken,
    output logic [Size-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_Depth);

    logic [1:0]       bht_q [BHT_Depth];
    logic [1:0]       bht_d [BHT_Depth];
    logic             out_valid_q, out_valid_d;
    logic             branch_taken_q, branch_taken_d;
    logic [Size-1:0]  redirect_pc_q, redirect_pc_d;
    logic             mispredict_q, mispredict_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] mcount_q, mcount_d;

    logic             accept;
    logic             legal;
    logic             cond_taken;
    logic             mis_c;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] pidx;
    logic [1:0]       ctr;

    assign pidx       = pred_pc[IDX_W+1:2];
    assign ridx       = resolve_pc[IDX_W+1:2];
    assign pred_taken = bht_q[pidx][1];
    assign accept     = resolve_valid & ~flush;

    // Decode func3 into the branch condition and legality
    always_comb begin
        legal      = 1'b1;
        cond_taken = 1'b0;
        case (func3)
            3'b000:  cond_taken = (rs1_data == rs2_data);
            3'b001:  cond_taken = (rs1_data != rs2_data);
            3'b100:  cond_taken = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  cond_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_taken = (rs1_data < rs2_data);
            3'b111:  cond_taken = (rs1_data >= rs2_data);
            default: legal = 1'b0;
        endcase
        mis_c = legal & (cond_taken ^ pred_taken_in);
    end

    // Next-state for registered results; outputs hold when nothing accepted
    always_comb begin
        out_valid_d    = accept;
        branch_taken_d = branch_taken_q;
        redirect_pc_d  = redirect_pc_q;
        mispredict_d   = mispredict_q;
        illegal_d      = illegal_q;
        mcount_d       = mcount_q;
        if (accept) begin
            branch_taken_d = cond_taken;
            redirect_pc_d  = cond_taken ? resolve_pc + imm
                                        : resolve_pc + Size'(4);
            mispredict_d   = mis_c;
            illegal_d      = ~legal;
            if (mis_c && (mcount_q != '1)) begin
                mcount_d = mcount_q + 1'b1;
            end
        end
    end

    // Saturating counter update for the resolved branch's BHT entry
    always_comb begin
        bht_d = bht_q;
        ctr   = bht_q[ridx];
        if (accept && legal) begin
            if (cond_taken) begin
                if (ctr != 2'b11) bht_d[ridx] = ctr + 2'b01;
            end else begin
                if (ctr != 2'b00) bht_d[ridx] = ctr - 2'b01;
            end
        end
    end

    // State registers; BHT resets to weakly-not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_Depth; i++) bht_q[i] <= 2'b01;
            out_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            redirect_pc_q  <= '0;
            mispredict_q   <= 1'b0;
            illegal_q      <= 1'b0;
            mcount_q       <= '0;
        end else begin
            bht_q          <= bht_d;
            out_valid_q    <= out_valid_d;
            branch_taken_q <= branch_taken_d;
            redirect_pc_q  <= redirect_pc_d;
            mispredict_q   <= mispredict_d;
            illegal_q      <= illegal_d;
            mcount_q       <= mcount_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign branch_taken     = branch_taken_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict       = mispredict_q;
    assign illegal          = illegal_q;
    assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed testbench for branch_unit: default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pred_pc, resolve_pc, rs1, rs2, imm;
    logic [2:0]  func3;
    logic        resolve_valid, pred_taken_in, flush;

    logic        pred_taken, out_valid, branch_taken, mispredict, illegal;
    logic [31:0] redirect_pc;
    logic [15:0] mcount;

    logic        p2_pred, p2_ov, p2_taken, p2_mis, p2_ill;
    logic [31:0] p2_redir;
    logic [1:0]  mcount2;

    int checks   = 0;
    int failures = 0;

    branch_unit dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .rs1_data(rs1), .rs2_data(rs2), .func3(func3), .imm(imm),
        .pred_taken_in(pred_taken_in), .flush(flush),
        .out_valid(out_valid), .branch_taken(branch_taken),
        .redirect_pc(redirect_pc), .mispredict(mispredict),
        .illegal(illegal), .mispredict_count(mcount)
    );

    branch_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(p2_pred),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .rs1_data(rs1), .rs2_data(rs2), .func3(func3), .imm(imm),
        .pred_taken_in(pred_taken_in), .flush(flush),
        .out_valid(p2_ov), .branch_taken(p2_taken),
        .redirect_pc(p2_redir), .mispredict(p2_mis),
        .illegal(p2_ill), .mispredict_count(mcount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic pti);
        resolve_pc    = pc;
        func3         = f3;
        rs1           = a;
        rs2           = b;
        imm           = im;
        pred_taken_in = pti;
        resolve_valid = 1'b1;
        flush         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred got=%0h exp=0", pred_taken); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0h exp=0", branch_taken); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redir got=%0h exp=0", redirect_pc); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rst_mis got=%0h exp=0", mispredict); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rst_ill got=%0h exp=0", illegal); end
        checks++; if (mcount !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", mcount); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_blt();
        issue(32'h200, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0);
        pred_pc = 32'h200;
        step();
        resolve_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL blt_valid got=%0h exp=1", out_valid); end
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL blt_taken got=%0h exp=1", branch_taken); end
        checks++; if (redirect_pc !== 32'h210) begin failures++; $display("FAIL blt_redir got=%0h exp=210", redirect_pc); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL blt_mis got=%0h exp=1", mispredict); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL blt_ill got=%0h exp=0", illegal); end
        checks++; if (mcount !== 16'd1) begin failures++; $display("FAIL blt_cnt got=%0d exp=1", mcount); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL blt_pred got=%0h exp=1", pred_taken); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0h exp=0", out_valid); end
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL idle_taken_hold got=%0h exp=1", branch_taken); end
        checks++; if (redirect_pc !== 32'h210) begin failures++; $display("FAIL idle_redir_hold got=%0h exp=210", redirect_pc); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL idle_mis_hold got=%0h exp=1", mispredict); end
    endtask

    task automatic test_bltu();
        issue(32'h200, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0);
        step();
        resolve_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bltu_valid got=%0h exp=1", out_valid); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL bltu_taken got=%0h exp=0", branch_taken); end
        checks++; if (redirect_pc !== 32'h204) begin failures++; $display("FAIL bltu_redir got=%0h exp=204", redirect_pc); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bltu_mis got=%0h exp=0", mispredict); end
        checks++; if (mcount !== 16'd1) begin failures++; $display("FAIL bltu_cnt got=%0d exp=1", mcount); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL bltu_pred got=%0h exp=0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        pred_pc = 32'h40;
        issue(32'h40, 3'b000, 32'h5, 32'h5, 32'hFFFF_FFF8, 1'b1);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_preupdate got=%0h exp=0", pred_taken); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, out_valid); end
            checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL b2b_taken[%0d] got=%0h exp=1", i, branch_taken); end
            checks++; if (redirect_pc !== 32'h38) begin failures++; $display("FAIL b2b_redir[%0d] got=%0h exp=38", i, redirect_pc); end
            checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL b2b_mis[%0d] got=%0h exp=0", i, mispredict); end
            checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL b2b_pred[%0d] got=%0h exp=1", i, pred_taken); end
        end
        resolve_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%0h exp=0", out_valid); end
    endtask

    task automatic test_wrap_and_signed();
        issue(32'hFFFF_FFFC, 3'b001, 32'h1, 32'h2, 32'h8, 1'b1);
        step();
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL bne_taken got=%0h exp=1", branch_taken); end
        checks++; if (redirect_pc !== 32'h4) begin failures++; $display("FAIL bne_wrap got=%0h exp=4", redirect_pc); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bne_mis got=%0h exp=0", mispredict); end
        issue(32'hFFFF_FFFC, 3'b000, 32'h1, 32'h2, 32'h8, 1'b0);
        step();
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL beq_nt_taken got=%0h exp=0", branch_taken); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL beq_nt_wrap got=%0h exp=0", redirect_pc); end
        issue(32'h300, 3'b101, 32'h8000_0000, 32'h0, 32'h40, 1'b1);
        step();
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL bge_taken got=%0h exp=0", branch_taken); end
        checks++; if (redirect_pc !== 32'h304) begin failures++; $display("FAIL bge_redir got=%0h exp=304", redirect_pc); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL bge_mis got=%0h exp=1", mispredict); end
        checks++; if (mcount !== 16'd2) begin failures++; $display("FAIL bge_cnt got=%0d exp=2", mcount); end
        issue(32'h300, 3'b111, 32'h8000_0000, 32'h0, 32'h40, 1'b1);
        step();
        resolve_valid = 1'b0;
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL bgeu_taken got=%0h exp=1", branch_taken); end
        checks++; if (redirect_pc !== 32'h340) begin failures++; $display("FAIL bgeu_redir got=%0h exp=340", redirect_pc); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bgeu_mis got=%0h exp=0", mispredict); end
    endtask

    task automatic test_illegal_flush();
        pred_pc = 32'h44;
        issue(32'h44, 3'b000, 32'h3, 32'h3, 32'h10, 1'b1);
        step();
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ill_train_pred got=%0h exp=1", pred_taken); end
        issue(32'h44, 3'b010, 32'h3, 32'h3, 32'h10, 1'b1);
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%0h exp=1", out_valid); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_010 got=%0h exp=1", illegal); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL ill_taken got=%0h exp=0", branch_taken); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL ill_mis got=%0h exp=0", mispredict); end
        checks++; if (mcount !== 16'd2) begin failures++; $display("FAIL ill_cnt got=%0d exp=2", mcount); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ill_bht got=%0h exp=1", pred_taken); end
        issue(32'h44, 3'b011, 32'h3, 32'h3, 32'h10, 1'b1);
        step();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_011 got=%0h exp=1", illegal); end
        issue(32'h44, 3'b001, 32'h3, 32'h3, 32'h10, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
        checks++; if (mcount !== 16'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", mcount); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL flush_ill_hold got=%0h exp=1", illegal); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL flush_bht got=%0h exp=1", pred_taken); end
        issue(32'h44, 3'b001, 32'h3, 32'h3, 32'h10, 1'b0);
        step();
        resolve_valid = 1'b0;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL post_ill got=%0h exp=0", illegal); end
        checks++; if (redirect_pc !== 32'h48) begin failures++; $display("FAIL post_redir got=%0h exp=48", redirect_pc); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL post_bht got=%0h exp=0", pred_taken); end
    endtask

    task automatic test_reset_mid();
        pred_pc = 32'h40;
        issue(32'h80, 3'b000, 32'h1, 32'h1, 32'h4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rmid_bht got=%0h exp=0", pred_taken); end
        checks++; if (mcount !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", mcount); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0h exp=0", out_valid); end
        resolve_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_post_valid got=%0h exp=0", out_valid); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2 [5];
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3;
        exp2[3] = 2'd3; exp2[4] = 2'd3;
        issue(32'h80, 3'b000, 32'h1, 32'h1, 32'h4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (mcount2 !== exp2[i]) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, mcount2, exp2[i]); end
            checks++; if (mcount !== 16'(i + 1)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, mcount, i + 1); end
            checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL sat_mis[%0d] got=%0h exp=1", i, mispredict); end
        end
        resolve_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        pred_pc       = 32'h100;
        resolve_pc    = '0;
        rs1           = '0;
        rs2           = '0;
        imm           = '0;
        func3         = '0;
        resolve_valid = 1'b0;
        pred_taken_in = 1'b0;
        flush         = 1'b0;
        test_reset();
        test_blt();
        test_bltu();
        test_back_to_back();
        test_wrap_and_signed();
        test_illegal_flush();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
